imem_program_loader: RTL

- Boot-time loader that sits directly upstream of the instruction memory and the PC.
- Receives a byte stream from the host over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses, then checks an XOR checksum.
- Releases the CPU pipeline (cpuRun_Loader) only after a verified load; the CPU is held in reset while cpuRun_Loader is low.

---
 rtl/imem_program_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/imem_program_loader.sv
// Boot loader: assembles little-endian words from a byte stream, writes them to
// instruction memory, verifies an XOR checksum, then releases the CPU.
module imem_program_loader #(
    parameter int         NUM_WORDS = 64,
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         ADDR_STEP = 4
) (
    input  logic        clk_Loader,
    input  logic        rst_n_Loader,
    input  logic        start_Loader,
    input  logic [7:0]  byteIn_Loader,
    input  logic        byteValid_Loader,
    output logic        byteReady_Loader,
    output logic        wrEn_Loader,
    output logic [7:0]  wrAddr_Loader,
    output logic [31:0] wrData_Loader,
    output logic        cpuRun_Loader,
    output logic        busy_Loader,
    output logic        error_Loader,
    output logic [7:0]  wordsLoaded_Loader
);

    localparam logic [7:0] MAX_WORDS = 8'(NUM_WORDS);

    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERR} state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_idx;
    logic [23:0] acc;
    logic [7:0]  csum;
    logic [7:0]  n_words;
    logic [7:0]  addr_k;
    logic        xfer;
    logic        load_start;
    logic        last_byte;

    assign byteReady_Loader = (state == COUNT) || (state == DATA) || (state == CHECK);
    assign busy_Loader      = byteReady_Loader;
    assign cpuRun_Loader    = (state == DONE);
    assign error_Loader     = (state == ERR);

    assign xfer       = byteValid_Loader && byteReady_Loader;
    assign load_start = start_Loader && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign last_byte  = (byte_idx == 2'd3);
    // Address wraps mod 256 by truncation.
    assign addr_k     = BASE_ADDR + 8'(32'(wordsLoaded_Loader) * ADDR_STEP);

    always_ff @(posedge clk_Loader or negedge rst_n_Loader) begin
        if (!rst_n_Loader) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start_Loader) state_nxt = COUNT;
            COUNT: begin
                if (xfer) begin
                    if (byteIn_Loader > MAX_WORDS)  state_nxt = ERR;
                    else if (byteIn_Loader == 8'd0) state_nxt = CHECK;
                    else                            state_nxt = DATA;
                end
            end
            DATA: begin
                if (xfer && last_byte && (8'(wordsLoaded_Loader + 8'd1) == n_words))
                    state_nxt = CHECK;
            end
            CHECK: begin
                if (xfer) state_nxt = (byteIn_Loader == csum) ? DONE : ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_Loader or negedge rst_n_Loader) begin
        if (!rst_n_Loader) begin
            byte_idx           <= '0;
            acc                <= '0;
            csum               <= '0;
            n_words            <= '0;
            wrEn_Loader        <= 1'b0;
            wrAddr_Loader      <= '0;
            wrData_Loader      <= '0;
            wordsLoaded_Loader <= '0;
        end else begin
            wrEn_Loader <= 1'b0;
            if (load_start) begin
                byte_idx           <= '0;
                csum               <= '0;
                n_words            <= '0;
                wordsLoaded_Loader <= '0;
            end
            if (state == COUNT && xfer)
                n_words <= byteIn_Loader;
            if (state == DATA && xfer) begin
                csum     <= csum ^ byteIn_Loader;
                byte_idx <= byte_idx + 2'd1;
                // Shift in LSB-first; the 4th byte lands on top of the word.
                acc      <= {byteIn_Loader, acc[23:8]};
                if (last_byte) begin
                    wrEn_Loader        <= 1'b1;
                    wrData_Loader      <= {byteIn_Loader, acc};
                    wrAddr_Loader      <= addr_k;
                    wordsLoaded_Loader <= wordsLoaded_Loader + 8'd1;
                end
            end
        end
    end

endmodule
